bmem_arbiter_rr: RTL and testbench

Parametrised arbiter that multiplexes NUM_PORTS cache-side clients onto the single burst-memory (bmem) port, replacing the fixed two-client icache/dcache arbiter. Grants are round-robin or fixed-priority, chosen by parameter. Multiple reads may be outstanding, each tagged with its requester so that read bursts return to the correct client. Write bursts of BURST_LEN beats are held atomically on the bus.

---
 rtl/bmem_arbiter_rr.sv | 176 +++++++++++++++++
 tb/tb_bmem_arbiter_rr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter_rr.sv
// Arbiter that puts NUM_PORTS burst clients onto one bmem port. Grants are round-robin
// or fixed priority. A read-tag FIFO routes each returned read burst to its requester.
module bmem_arbiter_rr #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PRIORITY_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [ADDR_W-1:0]           resp_raddr,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic [NUM_PORTS-1:0]        resp_rvalid,
  output logic [ADDR_W-1:0]           bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [DATA_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [ADDR_W-1:0]           bmem_raddr,
  input  logic [DATA_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid,
  output logic                        err_rvalid
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic {S_IDLE, S_WRITE_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_rr_ptr, r_owner;
  logic [BW-1:0]     r_beat_cnt, r_rbeat_cnt;
  logic [PW-1:0]     r_tag_mem [MAX_OUTSTANDING];
  logic [FW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_bmem_addr;
  logic [DATA_W-1:0] r_bmem_wdata;
  logic              r_bmem_read, r_bmem_write, r_err;

  logic [ADDR_W-1:0]    w_addr  [NUM_PORTS];
  logic [DATA_W-1:0]    w_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_elig;
  logic [PW-1:0]        w_win, w_head;
  logic                 w_has_room, w_grant, w_grant_wr, w_grant_rd;
  logic                 w_beat_in, w_pop, w_last_wbeat;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Round-robin scans from ptr with wrap; fixed priority scans from index 0.
  function automatic logic [PW-1:0] f_pick(input logic [NUM_PORTS-1:0] elig,
                                           input logic [PW-1:0]        ptr);
    logic [PW-1:0] win;
    logic          found;
    int            idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (PRIORITY_MODE != 0) ? k : (int'(ptr) + k) % NUM_PORTS;
      if (!found && elig[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    return win;
  endfunction

  function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
    return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // The registered count is used here, so a pop in this cycle frees no slot until the next one.
  assign w_has_room   = (r_count < CW'(MAX_OUTSTANDING));
  assign w_elig       = req_write | (req_read & {NUM_PORTS{w_has_room}});
  assign w_win        = f_pick(w_elig, r_rr_ptr);
  assign w_grant      = (r_state == S_IDLE) & rst_n & bmem_ready & (|w_elig);
  assign w_grant_wr   = w_grant & req_write[w_win];
  assign w_grant_rd   = w_grant & ~req_write[w_win];
  assign w_beat_in    = bmem_rvalid & (r_count != '0);
  assign w_head       = r_tag_mem[r_rd_ptr];
  assign w_pop        = w_beat_in & (r_rbeat_cnt == BW'(BURST_LEN - 1));
  assign w_last_wbeat = (r_beat_cnt == BW'(BURST_LEN - 1));

  assign bmem_addr  = r_bmem_addr;
  assign bmem_read  = r_bmem_read;
  assign bmem_write = r_bmem_write;
  assign bmem_wdata = r_bmem_wdata;
  assign err_rvalid = r_err;
  assign resp_raddr = bmem_raddr;
  assign resp_rdata = bmem_rdata;

  // NOTE: every output of an always_comb block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          req_ready[w_win] = 1'b1;
          if (req_write[w_win]) w_state_nxt = S_WRITE_BURST;
        end
      end
      S_WRITE_BURST: begin
        req_ready[r_owner] = 1'b1;
        if (w_last_wbeat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    resp_rvalid = '0;
    if (w_beat_in) resp_rvalid[w_head] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_beat_cnt   <= '0;
      r_rbeat_cnt  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bmem_addr  <= '0;
      r_bmem_wdata <= '0;
      r_bmem_read  <= 1'b0;
      r_bmem_write <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_bmem_read  <= w_grant_rd;
      r_bmem_write <= w_grant_wr | (r_state == S_WRITE_BURST);
      if (w_grant) begin
        r_bmem_addr <= w_addr[w_win];
        if (PRIORITY_MODE == 0)
          r_rr_ptr <= (w_win == PW'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
      end
      if (w_grant_wr) begin
        r_bmem_wdata <= w_wdata[w_win];
        r_owner      <= w_win;
        r_beat_cnt   <= BW'(1);
      end else if (r_state == S_WRITE_BURST) begin
        r_bmem_wdata <= w_wdata[r_owner];
        r_beat_cnt   <= w_last_wbeat ? '0 : r_beat_cnt + 1'b1;
      end
      if (w_grant_rd) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_beat_in)  r_rbeat_cnt <= w_pop ? '0 : r_rbeat_cnt + 1'b1;
      if (w_pop)      r_rd_ptr <= f_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_grant_rd) - CW'(w_pop);
      if (bmem_rvalid && (r_count == '0)) r_err <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; the FIFO pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_grant_rd) r_tag_mem[r_wr_ptr] <= w_win;
  end

endmodule

// File: tb/tb_bmem_arbiter_rr.sv
// Directed bench for bmem_arbiter_rr. One round-robin instance and one fixed-priority
// instance. Every expected value is worked out by hand.
module tb_bmem_arbiter_rr;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BL = 4;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NP*AW-1:0] req_addr;
  logic [NP-1:0]    req_read, req_write;
  logic [NP*DW-1:0] req_wdata;
  logic             bmem_ready;
  logic [AW-1:0]    bmem_raddr;
  logic [DW-1:0]    bmem_rdata;
  logic             bmem_rvalid;

  logic [NP-1:0] req_ready, resp_rvalid;
  logic [AW-1:0] resp_raddr, bmem_addr;
  logic [DW-1:0] resp_rdata, bmem_wdata;
  logic          bmem_read, bmem_write, err_rvalid;

  logic [NP-1:0] p_req_read, p_req_write, p_req_ready, p_resp_rvalid;
  logic          p_bmem_ready, p_bmem_rvalid;
  logic [AW-1:0] p_resp_raddr, p_bmem_addr;
  logic [DW-1:0] p_resp_rdata, p_bmem_wdata;
  logic          p_bmem_read, p_bmem_write, p_err_rvalid;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] wb [BL] = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                             64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
  logic [NP-1:0] ord [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  bmem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
                    .MAX_OUTSTANDING(MO), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_read(req_read),
    .req_write(req_write), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_raddr(resp_raddr), .resp_rdata(resp_rdata), .resp_rvalid(resp_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err_rvalid(err_rvalid)
  );

  bmem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL),
                    .MAX_OUTSTANDING(MO), .PRIORITY_MODE(1)) dut_pri (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_read(p_req_read),
    .req_write(p_req_write), .req_wdata(req_wdata), .req_ready(p_req_ready),
    .resp_raddr(p_resp_raddr), .resp_rdata(p_resp_rdata), .resp_rvalid(p_resp_rvalid),
    .bmem_addr(p_bmem_addr), .bmem_read(p_bmem_read), .bmem_write(p_bmem_write),
    .bmem_wdata(p_bmem_wdata), .bmem_ready(p_bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(p_bmem_rvalid), .err_rvalid(p_err_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wdata(input int i, input logic [DW-1:0] d);
    req_wdata[i*DW +: DW] = d;
  endtask

  function automatic logic [AW-1:0] rr_addr(input int i);
    return 32'h1000 * i + 32'h40;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_addr = '0; req_read = '0; req_write = '0; req_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    p_req_read = '0; p_req_write = '0; p_bmem_ready = 1'b1; p_bmem_rvalid = 1'b0;

    #2;
    chk("rst_bmem_read", bmem_read, 0);
    chk("rst_bmem_write", bmem_write, 0);
    chk("rst_bmem_addr", bmem_addr, 0);
    chk("rst_bmem_wdata", bmem_wdata, 0);
    chk("rst_resp_rvalid", resp_rvalid, 0);
    chk("rst_err", err_rvalid, 0);
    req_read = 4'b0010;
    set_addr(1, 32'h100);
    #1 chk("rst_req_ready", req_ready, 0);

    // Single read from client 1
    tick();
    rst_n = 1'b1;
    #1 chk("t1_grant", req_ready, 4'b0010);
    tick();
    req_read = '0;
    #1;
    chk("t1_bmem_read", bmem_read, 1);
    chk("t1_bmem_addr", bmem_addr, 32'h100);
    chk("t1_bmem_write", bmem_write, 0);
    for (int k = 0; k < BL; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = 64'hBEEF_0000 + 64'(k);
      #1 chk("t1_route", resp_rvalid, 4'b0010);
      if (k == 2) chk("t1_rdata", resp_rdata, 64'hBEEF_0002);
      tick();
    end
    bmem_rvalid = 1'b0;
    #1;
    chk("t1_idle_read", bmem_read, 0);
    chk("t1_addr_hold", bmem_addr, 32'h100);
    chk("t1_no_route", resp_rvalid, 0);
    chk("t1_no_err", err_rvalid, 0);

    // Round-robin, four reads fill the tag FIFO
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < NP; i++) set_addr(i, rr_addr(i));
    req_read = 4'b1111;
    #1 chk("rr_grant0", req_ready, 4'b0001);
    for (int k = 1; k < NP; k++) begin
      tick();
      if (k > 1) req_read[k-1] = 1'b0;
      #1;
      chk("rr_grant", req_ready, 64'(1 << k));
      chk("rr_addr", bmem_addr, rr_addr(k - 1));
      chk("rr_read", bmem_read, 1);
    end
    tick();
    req_read[3] = 1'b0;
    #1;
    chk("rr_addr3", bmem_addr, rr_addr(3));
    chk("rr_blocked", req_ready, 0);
    for (int k = 0; k < BL; k++) begin
      bmem_rvalid = 1'b1;
      #1;
      chk("rr_route0", resp_rvalid, 4'b0001);
      chk("rr_still_blocked", req_ready, 0);
      tick();
    end
    bmem_rvalid = 1'b0;
    #1 chk("rr_fifth_grant", req_ready, 4'b0001);
    tick();
    req_read = '0;
    #1;
    chk("rr_fifth_addr", bmem_addr, rr_addr(0));
    chk("rr_fifth_read", bmem_read, 1);

    // Drain in tag order 1,2,3,0
    for (int k = 0; k < 4 * BL; k++) begin
      bmem_rvalid = 1'b1;
      #1 chk("ooo_route", resp_rvalid, ord[k / BL]);
      tick();
    end

    // Stray beat with the FIFO empty
    #1;
    chk("stray_route", resp_rvalid, 0);
    chk("stray_err_pre", err_rvalid, 0);
    tick();
    bmem_rvalid = 1'b0;
    #1 chk("stray_err", err_rvalid, 1);
    tick();
    #1;
    chk("stray_sticky", err_rvalid, 1);
    chk("stray_no_route", resp_rvalid, 0);

    // Write burst from client 2 while client 0 requests a read
    set_addr(2, 32'h2200);
    set_addr(0, 32'h0400);
    set_wdata(2, wb[0]);
    req_write = 4'b0100;
    req_read  = 4'b0001;
    #1 chk("wr_grant", req_ready, 4'b0100);
    for (int k = 1; k < BL; k++) begin
      tick();
      set_wdata(2, wb[k]);
      bmem_ready = 1'b0;
      #1;
      chk("wr_ready_hold", req_ready, 4'b0100);
      chk("wr_bmem_write", bmem_write, 1);
      chk("wr_no_read", bmem_read, 0);
      chk("wr_beat", bmem_wdata, wb[k-1]);
      chk("wr_addr", bmem_addr, 32'h2200);
    end
    tick();
    req_write  = '0;
    bmem_ready = 1'b1;
    #1;
    chk("wr_last_beat", bmem_wdata, wb[BL-1]);
    chk("wr_last_write", bmem_write, 1);
    chk("wr_next_grant", req_ready, 4'b0001);
    tick();
    req_read = '0;
    #1;
    chk("rd_after_wr_read", bmem_read, 1);
    chk("rd_after_wr_write", bmem_write, 0);
    chk("rd_after_wr_addr", bmem_addr, 32'h0400);
    chk("rd_after_wr_wdata", bmem_wdata, wb[BL-1]);

    // Fixed priority: clients 0 and 3 request continuously
    p_req_read = 4'b1001;
    for (int k = 0; k < MO; k++) begin
      #1 chk("pri_grant", p_req_ready, 4'b0001);
      tick();
    end
    #1;
    chk("pri_blocked", p_req_ready, 0);
    chk("pri_addr", p_bmem_addr, 32'h0400);
    tick();
    #1 chk("pri_blocked2", p_req_ready, 0);
    p_req_read = '0;

    // Reset asserted during a write burst
    set_wdata(1, 64'h5555);
    req_write = 4'b0010;
    #1 chk("rst_mid_grant", req_ready, 4'b0010);
    tick();
    #1 chk("rst_mid_write", bmem_write, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bmem_write", bmem_write, 0);
    chk("rst_mid_ready", req_ready, 0);
    chk("rst_mid_addr", bmem_addr, 0);
    chk("rst_mid_err_clr", err_rvalid, 0);
    rst_n = 1'b1;
    req_write = '0;
    bmem_rvalid = 1'b1;
    #1 chk("rst_mid_route", resp_rvalid, 0);
    tick();
    bmem_rvalid = 1'b0;
    #1 chk("rst_mid_err", err_rvalid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
